// File: rtl/pi_dco_combiner.sv
// Loop-filter output stage of the digital PLL: merges the integral candidate with a
// saturated proportional kick into a decimated DCO control word and tracks bang-bang lock.
module pi_dco_combiner #(
   parameter int unsigned P          = 4000,
   parameter int unsigned DEC        = 1,
   parameter int unsigned LOCK_CNT   = 16,
   parameter int unsigned UNLOCK_RUN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x,
   input  logic [19:0] ki_add,
   input  logic [19:0] ki_sub,
   output logic [19:0] dco_word,
   output logic        upd,
   output logic        locked
);

   localparam logic [19:0] WORD_MAX  = 20'hFFFFF;
   localparam logic [20:0] P_EXT     = 21'(P);
   localparam logic [9:0]  DEC_LAST  = 10'(DEC - 1);
   localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
   localparam logic [7:0]  RUN_LAST  = 8'(UNLOCK_RUN - 2);

   typedef enum logic {
      ACQUIRE,
      LOCKED
   } lockState_e;

   lockState_e  state_q, state_d;
   logic [19:0] dco_word_q, dco_word_d;
   logic        upd_q, upd_d;
   logic [9:0]  dec_cnt_q, dec_cnt_d;
   logic [7:0]  alt_cnt_q, alt_cnt_d;
   logic [7:0]  run_cnt_q, run_cnt_d;
   logic        prev_x_q;

   logic [19:0] integ;
   logic [20:0] integExt;
   logic [20:0] sumUp;
   logic [20:0] diffDn;
   logic [19:0] result;
   logic        decHit;
   logic        alt;

   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // The selected candidate already equals the integrator value after this edge.
   assign integ    = x ? ki_add : ki_sub;
   assign integExt = {1'b0, integ};
   assign sumUp    = integExt + P_EXT;
   assign diffDn   = integExt - P_EXT;

   always_comb begin
      result = '0;
      if (x) begin
         result = sumUp[20] ? WORD_MAX : sumUp[19:0];
      end else if (integExt >= P_EXT) begin
         result = diffDn[19:0];
      end
   end

   assign decHit = (dec_cnt_q == DEC_LAST);

   always_comb begin
      dec_cnt_d  = decHit ? 10'd0 : dec_cnt_q + 10'd1;
      dco_word_d = decHit ? result : dco_word_q;
      upd_d      = decHit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dco_word_q <= '0;
         upd_q      <= 1'b0;
         dec_cnt_q  <= '0;
         prev_x_q   <= 1'b0;
         alt_cnt_q  <= '0;
         run_cnt_q  <= '0;
      end else begin
         dco_word_q <= dco_word_d;
         upd_q      <= upd_d;
         dec_cnt_q  <= dec_cnt_d;
         prev_x_q   <= x;
         alt_cnt_q  <= alt_cnt_d;
         run_cnt_q  <= run_cnt_d;
      end
   end

   assign alt = (x != prev_x_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ACQUIRE;
      end else begin
         state_q <= state_d;
      end
   end

   // Lock runs every cycle, independent of the decimation counter.
   always_comb begin
      state_d   = state_q;
      alt_cnt_d = alt_cnt_q;
      run_cnt_d = run_cnt_q;
      unique case (state_q)
         ACQUIRE: begin
            if (alt) begin
               if (alt_cnt_q == LOCK_LAST) begin
                  state_d   = LOCKED;
                  run_cnt_d = '0;
               end
               alt_cnt_d = satInc(alt_cnt_q);
            end else begin
               alt_cnt_d = '0;
            end
         end
         LOCKED: begin
            if (!alt) begin
               if (run_cnt_q == RUN_LAST) begin
                  state_d   = ACQUIRE;
                  alt_cnt_d = '0;
               end
               run_cnt_d = satInc(run_cnt_q);
            end else begin
               run_cnt_d = '0;
            end
         end
         default: state_d = ACQUIRE;
      endcase
   end

   always_comb begin
      locked = (state_q == LOCKED);
   end

   assign dco_word = dco_word_q;
   assign upd      = upd_q;

endmodule

// File: tb/tb_pi_dco_combiner.sv
// Directed bench for pi_dco_combiner: a DEC=1 instance for datapath/lock and a DEC=4 instance for decimation.
module tb_pi_dco_combiner;

   logic        clk;
   logic        rst;
   logic        x;
   logic [19:0] kiAdd;
   logic [19:0] kiSub;
   logic [19:0] dcoWord1, dcoWord4;
   logic        upd1, upd4;
   logic        locked1, locked4;

   int compared;
   int mismatched;
   logic xv;

   pi_dco_combiner #(.P(4000), .DEC(1), .LOCK_CNT(16), .UNLOCK_RUN(8)) dut1 (
      .clk(clk), .rst(rst), .x(x), .ki_add(kiAdd), .ki_sub(kiSub),
      .dco_word(dcoWord1), .upd(upd1), .locked(locked1)
   );

   pi_dco_combiner #(.P(4000), .DEC(4), .LOCK_CNT(16), .UNLOCK_RUN(8)) dut4 (
      .clk(clk), .rst(rst), .x(x), .ki_add(kiAdd), .ki_sub(kiSub),
      .dco_word(dcoWord4), .upd(upd4), .locked(locked4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Expected word for P=4000 straight from the arithmetic definition.
   function automatic logic [19:0] expectWord(input logic xi, input logic [19:0] ka, input logic [19:0] ks);
      int integ;
      int r;
      integ = xi ? int'(ka) : int'(ks);
      if (xi) r = (integ + 4000 > 1048575) ? 1048575 : integ + 4000;
      else    r = (integ < 4000) ? 0 : integ - 4000;
      return 20'(r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      compared++;
      if (dcoWord1 !== 20'd0 || upd1 !== 1'b0 || locked1 !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_dut1: got word=%0d upd=%b locked=%b, want 0/0/0", dcoWord1, upd1, locked1);
      end
      step();
      compared++;
      if (dcoWord4 !== 20'd0 || upd4 !== 1'b0 || locked4 !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_dut4: got word=%0d upd=%b locked=%b, want 0/0/0", dcoWord4, upd4, locked4);
      end
   endtask

   task automatic test_basic();
      doReset();
      x = 1'b1; kiAdd = 20'd30000; kiSub = 20'd10000;
      step();
      compared++;
      if (dcoWord1 !== 20'd34000 || upd1 !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_up: got word=%0d upd=%b, want 34000/1", dcoWord1, upd1);
      end
      x = 1'b0;
      step();
      compared++;
      if (dcoWord1 !== 20'd6000 || upd1 !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL basic_down: got word=%0d upd=%b, want 6000/1", dcoWord1, upd1);
      end
   endtask

   task automatic test_saturation();
      logic        xs [5]    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [19:0] vals [5]  = '{20'd2000, 20'd1046000, 20'd1044575, 20'd4000, 20'd4001};
      logic [19:0] wants [5] = '{20'd0, 20'd1048575, 20'd1048575, 20'd0, 20'd1};
      for (int i = 0; i < 5; i++) begin
         x = xs[i];
         kiAdd = vals[i];
         kiSub = vals[i];
         step();
         compared++;
         if (dcoWord1 !== wants[i]) begin
            mismatched++;
            $display("[TB] FAIL saturation_%0d: got word=%0d, want %0d", i, dcoWord1, wants[i]);
         end
      end
   endtask

   task automatic test_decimation();
      logic [19:0] lastWord;
      logic        wantUpd;
      lastWord = 20'd0;
      doReset();
      x = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         kiAdd = 20'(i * 10000);
         step();
         wantUpd = (i % 4 == 0);
         if (wantUpd) lastWord = 20'(i * 10000 + 4000);
         compared++;
         if (dcoWord4 !== lastWord || upd4 !== wantUpd) begin
            mismatched++;
            $display("[TB] FAIL decimation_edge%0d: got word=%0d upd=%b, want %0d/%b",
                     i, dcoWord4, upd4, lastWord, wantUpd);
         end
      end
   endtask

   task automatic test_lock();
      logic wantLocked;
      doReset();
      kiAdd = 20'd5000; kiSub = 20'd5000;
      for (int i = 1; i <= 16; i++) begin
         x = (i % 2 == 1);
         step();
         wantLocked = (i == 16);
         compared++;
         if (locked1 !== wantLocked) begin
            mismatched++;
            $display("[TB] FAIL lock_acquire_edge%0d: got locked=%b, want %b", i, locked1, wantLocked);
         end
      end
      x = 1'b1;
      for (int j = 17; j <= 24; j++) begin
         step();
         wantLocked = (j < 24);
         compared++;
         if (locked1 !== wantLocked) begin
            mismatched++;
            $display("[TB] FAIL lock_run_edge%0d: got locked=%b, want %b", j, locked1, wantLocked);
         end
      end
      xv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         xv = ~xv; x = xv;
         step();
         compared++;
         if (locked1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lock_partial_%0d: got locked=%b, want 0", i, locked1);
         end
      end
      step();
      compared++;
      if (locked1 !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL lock_repeat: got locked=%b, want 0", locked1);
      end
      for (int k = 1; k <= 16; k++) begin
         xv = ~xv; x = xv;
         step();
         wantLocked = (k == 16);
         compared++;
         if (locked1 !== wantLocked) begin
            mismatched++;
            $display("[TB] FAIL lock_reacquire_%0d: got locked=%b, want %b", k, locked1, wantLocked);
         end
      end
   endtask

   task automatic test_interplay();
      int          e;
      logic [19:0] want;
      e = 0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 8; k++) begin
            if (k == 0 || k >= 5) xv = ~xv;
            x = xv;
            kiAdd = (e % 4 == 0) ? 20'(1044000 + e * 100) : 20'(200000 + e * 1234);
            kiSub = 20'(e * 900);
            want = expectWord(xv, kiAdd, kiSub);
            step();
            compared++;
            if (locked1 !== 1'b1 || dcoWord1 !== want) begin
               mismatched++;
               $display("[TB] FAIL interplay_edge%0d: got word=%0d locked=%b, want %0d/1", e, dcoWord1, locked1, want);
            end
            e++;
         end
      end
   endtask

   task automatic test_reset_midrun();
      xv = ~xv; x = xv;
      kiAdd = 20'd46000; kiSub = 20'd54000;
      step();
      compared++;
      if (dcoWord1 !== 20'd50000 || locked1 !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL midrun_setup: got word=%0d locked=%b, want 50000/1", dcoWord1, locked1);
      end
      #2;
      rst = 1'b0;
      #1;
      compared++;
      if (dcoWord1 !== 20'd0 || upd1 !== 1'b0 || locked1 !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrun_async_reset: got word=%0d upd=%b locked=%b, want 0/0/0", dcoWord1, upd1, locked1);
      end
      @(negedge clk);
      rst = 1'b1;
      x = 1'b1; kiAdd = 20'd10000; kiSub = 20'd0;
      step();
      compared++;
      if (dcoWord1 !== 20'd14000 || upd1 !== 1'b1 || locked1 !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midrun_release: got word=%0d upd=%b locked=%b, want 14000/1/0", dcoWord1, upd1, locked1);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst   = 1'b0;
      x     = 1'b0;
      kiAdd = 20'd0;
      kiSub = 20'd0;
      xv    = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_decimation();
      test_lock();
      test_interplay();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
